fp_addsub_arbiter: RTL and testbench
====================================

Name: fp_addsub_arbiter

Overview:
- Shares one fixed-latency, fully pipelined 7-bit floating-point add/sub unit between NREQ requesters (e.g. matrix row engines).
- Number format: [6:4] exponent, [3:0] mantissa.
- Round-robin arbitration, valid/ready handshake on the request side, registered issue to the unit.
- Tracks the requester tag through a LAT-deep pipeline and returns each result only to the requester that issued it.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LAT, 3, latency of the shared unit in cycles, from fu_valid sampled to fu_result valid (must be >= 1).
- W, 7, operand/result width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  grant/accept, one bit per requester.
- req_a  in  NREQ*W  operand A per requester; requester i occupies [i*W +: W].
- req_b  in  NREQ*W  operand B per requester, same packing.
- req_op  in  NREQ  0 = add, 1 = subtract, per requester.
- fu_valid  out  1  issue strobe to the shared unit.
- fu_a  out  W  issued operand A.
- fu_b  out  W  issued operand B.
- fu_op  out  1  issued operation.
- fu_result  in  W  unit result, valid exactly LAT cycles after the matching fu_valid cycle.
- rsp_valid  out  NREQ  one-hot result strobe, one cycle.
- rsp_data  out  W  result, shared by all requesters.
- busy  out  1  any operation is in flight (issue register or tag pipeline).

Behaviour:
- Reset (async, rst_n=0): fu_valid=0, fu_a=0, fu_b=0, fu_op=0, rsp_valid=0, rsp_data=0, busy=0, rr_ptr=0, all tag-pipeline valid bits 0.
- Arbitration (combinational): grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready = one-hot grant; at most one bit high.
  - req_ready = 0 when no request is valid.
  - No backpressure from the unit: a grant is possible every cycle.
- Handshake: the request is accepted at an edge where req_valid[i] & req_ready[i].
  - At that edge, rr_ptr <= (i+1) mod NREQ.
  - No acceptance leaves rr_ptr unchanged.
  - Requesters hold a, b and op stable while valid and not ready.
  - A requester may drop valid without being granted; no state changes.
- Issue stage (registered): the acceptance edge loads fu_a/fu_b/fu_op from the granted requester and sets fu_valid=1.
  - A cycle with no acceptance gives fu_valid=0; fu_a/fu_b/fu_op hold their values.
- Tag pipeline: LAT stages of {valid, tag[clog2(NREQ)-1:0]}, advancing every cycle.
  - Stage 0 loads {fu_valid, tag of the issued requester}.
  - The last stage aligns with fu_result.
- Response (registered): when the last stage is valid with tag t:
  - rsp_valid <= one-hot(t), rsp_data <= fu_result.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: a request accepted at edge k gives rsp_valid visible after edge k+1+LAT (edge k+4 for LAT=3).
- Throughput: one accepted request per cycle. Responses come back in issue order, back-to-back with no gaps lost.
- busy = fu_valid | OR of the tag-stage valid bits. It excludes the rsp register.
- Simultaneous events: acceptance, in-flight advance and response emission all occur in the same cycle, independently.
- Reset mid-operation: all in-flight tags are discarded. No response is ever produced for an operation accepted before reset. rr_ptr returns to 0.
- No arithmetic is done here. Operands and results pass bit-exact; alignment and rounding belong to the shared unit.

Test Plan:
- Reset, then requester 0 issues a=7'h35, b=7'h21, op=0 at edge 1:
  - req_ready=2'b01 at that edge, fu_valid=1 with fu_a=7'h35, fu_b=7'h21 after edge 1.
  - Model unit returns 7'h3C; rsp_valid=2'b01, rsp_data=7'h3C after edge 5.
- Both requesters hold req_valid=2'b11 for 6 cycles:
  - grants alternate 01,10,01,10,01,10.
  - Responses return in the same order, LAT+1 cycles after each grant, one per cycle.
- Only requester 1 valid for 3 cycles while rr_ptr=0:
  - grants 10 every cycle, rr_ptr stays at 0 after each (since (1+1) mod 2 = 0).
  - Then both valid gives grant 01.
- Requester 0 issues with op=1, a=7'h44, b=7'h12:
  - fu_op=1 registered.
  - busy high from the edge after acceptance through LAT cycles; busy=0 once the response is emitted.
- Issue two requests, assert rst_n=0 two cycles later for one cycle:
  - rsp_valid never asserts for either request; busy=0, req_ready resumes granting requester 0 first.
- Idle bus: req_valid=0 for 10 cycles → fu_valid=0, rsp_valid=0, busy=0, fu_a/fu_b hold their last values.

Source files
------------

// File: rtl/fp_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// fp_addsub_arbiter
//
// Shares one fixed-latency, fully pipelined floating-point add/sub unit
// between NREQ requesters. A round-robin arbiter grants one requester per
// cycle, the accepted operands are registered and issued to the unit, and
// the requester tag travels alongside the operation through a LAT-deep tag
// pipeline so each result is returned only to the requester that issued it.
// Operands and results pass through bit-exact; no arithmetic is done here.
//
// Parameters:
//   NREQ  number of requesters (2..4)
//   LAT   unit latency, fu_valid cycle to fu_result cycle (>= 1)
//   W     operand/result width ([6:4] exponent, [3:0] mantissa for W=7)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]    request valid per requester
//   req_ready  out  [NREQ]    one-hot grant (combinational)
//   req_a      in   [NREQ*W]  operand A, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]  operand B, same packing
//   req_op     in   [NREQ]    0 = add, 1 = subtract
//   fu_valid   out            registered issue strobe to the shared unit
//   fu_a       out  [W]       issued operand A
//   fu_b       out  [W]       issued operand B
//   fu_op      out            issued operation
//   fu_result  in   [W]       unit result, LAT cycles after fu_valid
//   rsp_valid  out  [NREQ]    one-hot, one-cycle result strobe
//   rsp_data   out  [W]       result, shared by all requesters
//   busy       out            an operation sits in the issue register or
//                             the tag pipeline
// ---------------------------------------------------------------------------
module fp_addsub_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 3,
    parameter int W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_op,
    output logic              fu_valid,
    output logic [W-1:0]      fu_a,
    output logic [W-1:0]      fu_b,
    output logic              fu_op,
    input  logic [W-1:0]      fu_result,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              busy
);

    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [TW-1:0] tag_t;

    // Index p+k wrapped into 0..NREQ-1; both operands are already < NREQ.
    function automatic tag_t wrap_add(input tag_t p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return tag_t'(s);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    tag_t            rr_ptr_q, rr_ptr_d;
    tag_t            cand_idx;
    tag_t            grant_idx;
    logic            accept;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    sel_a, sel_b;
    logic            sel_op;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch forms.
    always_comb begin
        cand_idx  = '0;
        grant_idx = '0;
        accept    = 1'b0;
        // Search starts at rr_ptr and wraps; the first valid requester wins.
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = wrap_add(rr_ptr_q, k);
            if (!accept && req_valid[cand_idx]) begin
                accept    = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant    = accept ? (NREQ'(1) << grant_idx) : '0;
        rr_ptr_d = accept ? wrap_add(grant_idx, 1) : rr_ptr_q;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == tag_t'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    logic         fu_valid_q;
    logic [W-1:0] fu_a_q, fu_b_q;
    logic         fu_op_q;
    tag_t         issue_tag_q;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            fu_valid_q  <= 1'b0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_op_q     <= 1'b0;
            issue_tag_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            fu_valid_q <= accept;
            // Operands hold between issues; only the strobe drops.
            if (accept) begin
                fu_a_q      <= sel_a;
                fu_b_q      <= sel_b;
                fu_op_q     <= sel_op;
                issue_tag_q <= grant_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 loads with the unit's sampling edge, so the
    // last stage lines up with fu_result.
    // ------------------------------------------------------------------
    logic [LAT-1:0] pipe_v_q;
    tag_t           pipe_t_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q <= '0;
        end else begin
            pipe_v_q[0] <= fu_valid_q;
            for (int i = 1; i < LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
            end
        end
    end

    // NOTE: the tag array carries no reset; its contents are only used when
    // the matching valid bit is set, and that valid bit is reset.
    always_ff @(posedge clk) begin
        pipe_t_q[0] <= issue_tag_q;
        for (int i = 1; i < LAT; i++) begin
            pipe_t_q[i] <= pipe_t_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic [NREQ-1:0] rsp_valid_q;
    logic [W-1:0]    rsp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else if (pipe_v_q[LAT-1]) begin
            rsp_valid_q <= NREQ'(1) << pipe_t_q[LAT-1];
            rsp_data_q  <= fu_result;
        end else begin
            rsp_valid_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = grant;
    assign fu_valid  = fu_valid_q;
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign fu_op     = fu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    // The response register is deliberately excluded from busy.
    assign busy      = fu_valid_q | (|pipe_v_q);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_arbiter
//
// Self-checking bench for fp_addsub_arbiter. A stand-in for the shared unit
// returns a fresh random value LAT cycles after each issue. A transaction
// model (round-robin pointer, queue of outstanding operations with due
// cycles, queue of unit results) predicts every output each cycle; scenario
// tasks add directed checks on top.
// ---------------------------------------------------------------------------
module tb_fp_addsub_arbiter;

    localparam int NREQ = 2;
    localparam int LAT  = 3;
    localparam int W    = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_op = '0;
    logic              fu_valid;
    logic [W-1:0]      fu_a, fu_b;
    logic              fu_op;
    logic [W-1:0]      fu_result;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .fu_valid  (fu_valid),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_op     (fu_op),
        .fu_result (fu_result),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Shared-unit stand-in: a fresh value enters the pipe every cycle; the
    // ones sampled with fu_valid are remembered in issue order.
    // ------------------------------------------------------------------
    logic [W-1:0] u_data [LAT];
    logic [W-1:0] u_vals [$];
    bit           force_next = 1'b0;
    logic [W-1:0] force_val  = '0;

    initial for (int i = 0; i < LAT; i++) u_data[i] = '0;

    always @(posedge clk) begin
        logic [W-1:0] v;
        v = W'($urandom);
        if (fu_valid === 1'b1) begin
            if (force_next) begin
                v          = force_val;
                force_next = 1'b0;
            end
            u_vals.push_back(v);
        end
        u_data[0] <= v;
        for (int i = 1; i < LAT; i++) u_data[i] <= u_data[i-1];
    end

    assign fu_result = u_data[LAT-1];

    // ------------------------------------------------------------------
    // Transaction model
    // ------------------------------------------------------------------
    typedef struct {
        int tag;
        int due;
    } pend_t;

    pend_t        pend [$];
    int           cyc        = 0;
    int           m_ptr      = 0;
    logic         m_fu_valid = 1'b0;
    logic [W-1:0] m_fu_a     = '0;
    logic [W-1:0] m_fu_b     = '0;
    logic         m_fu_op    = 1'b0;
    logic [W-1:0] m_rsp_data = '0;
    bit           mon_en     = 1'b0;

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr      = 0;
            m_fu_valid = 1'b0;
            m_fu_a     = '0;
            m_fu_b     = '0;
            m_fu_op    = 1'b0;
            m_rsp_data = '0;
            pend.delete();
            u_vals.delete();
        end else begin
            logic [NREQ-1:0] g;
            g = model_grant(req_valid, m_ptr);
            cyc++;
            m_fu_valid = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    m_fu_valid = 1'b1;
                    m_fu_a     = req_a[i*W +: W];
                    m_fu_b     = req_b[i*W +: W];
                    m_fu_op    = req_op[i];
                    pend.push_back('{tag: i, due: cyc + 1 + LAT});
                    m_ptr      = (i + 1) % NREQ;
                end
            end
        end
    end

    // Compares every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] e_rv;
        logic [NREQ-1:0] e_rdy;
        logic            e_busy;
        if (mon_en) begin
            e_rdy  = model_grant(req_valid, m_ptr);
            e_busy = m_fu_valid;
            foreach (pend[j]) if (pend[j].due > cyc) e_busy = 1'b1;
            e_rv = '0;
            if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
                e_rv = NREQ'(1) << pend[0].tag;
                pend.pop_front();
                checks++;
                if (u_vals.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unit_issue cyc=%0d: response due but unit saw no matching issue", cyc);
                end else begin
                    m_rsp_data = u_vals.pop_front();
                end
            end
            checks++;
            if (req_ready !== e_rdy) begin
                errors++;
                $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy);
            end
            checks++;
            if (fu_valid !== m_fu_valid) begin
                errors++;
                $display("FAIL mon_fu_valid cyc=%0d got=%b exp=%b", cyc, fu_valid, m_fu_valid);
            end
            checks++;
            if ({fu_op, fu_a, fu_b} !== {m_fu_op, m_fu_a, m_fu_b}) begin
                errors++;
                $display("FAIL mon_fu_operands cyc=%0d got op=%b a=%h b=%h exp op=%b a=%h b=%h",
                         cyc, fu_op, fu_a, fu_b, m_fu_op, m_fu_a, m_fu_b);
            end
            checks++;
            if (rsp_valid !== e_rv) begin
                errors++;
                $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rv);
            end
            checks++;
            if (rsp_data !== m_rsp_data) begin
                errors++;
                $display("FAIL mon_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, m_rsp_data);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i]       = op;
    endtask

    task automatic rand_req(input int i);
        set_req(i, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n  = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1 rst_n  = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fu_valid, fu_a, fu_b, fu_op, rsp_valid, rsp_data, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state got fu_v=%b a=%h b=%h op=%b rsp_v=%b rsp_d=%h busy=%b rdy=%b exp all zero",
                     fu_valid, fu_a, fu_b, fu_op, rsp_valid, rsp_data, busy, req_ready);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        req_valid  = 2'b01;
        set_req(0, 7'h35, 7'h21, 1'b0);
        force_val  = 7'h3C;
        force_next = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant got=%b exp=01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checks++;
        if ({fu_valid, fu_a, fu_b, fu_op} !== {1'b1, 7'h35, 7'h21, 1'b0}) begin
            errors++;
            $display("FAIL single_issue got v=%b a=%h b=%h op=%b exp v=1 a=35 b=21 op=0",
                     fu_valid, fu_a, fu_b, fu_op);
        end
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 7'h3C) begin
            errors++;
            $display("FAIL single_response got v=%b d=%h exp v=01 d=3c", rsp_valid, rsp_data);
        end
        drain();
    endtask

    task automatic test_alternate();
        logic [NREQ-1:0] exp_g;
        apply_reset();
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        for (int n = 0; n <= 5 + LAT + 2; n++) begin
            @(negedge clk);
            if (n < 6) begin
                exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_ready !== exp_g) begin
                    errors++;
                    $display("FAIL alt_grant n=%0d got=%b exp=%b", n, req_ready, exp_g);
                end
            end
            if (n >= LAT + 2) begin
                exp_g = ((n - LAT - 2) % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (rsp_valid !== exp_g) begin
                    errors++;
                    $display("FAIL alt_response n=%0d got=%b exp=%b", n, rsp_valid, exp_g);
                end
            end
            @(posedge clk);
            #1;
            if (n < 5) rand_req(n % 2);
            if (n == 5) req_valid = '0;
        end
        drain();
    endtask

    task automatic test_only_req1();
        apply_reset();
        rand_req(1);
        req_valid = 2'b10;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b10) begin
                errors++;
                $display("FAIL only1_grant n=%0d got=%b exp=10", n, req_ready);
            end
            @(posedge clk);
            #1 rand_req(1);
        end
        rand_req(0);
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL only1_then_both got=%b exp=01", req_ready);
        end
        @(posedge clk);
        #1 drain();
    endtask

    task automatic test_sub_busy();
        set_req(0, 7'h44, 7'h12, 1'b1);
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL sub_grant got=%b exp=01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        for (int n = 0; n <= LAT; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checks++;
                if ({fu_op, fu_a, fu_b} !== {1'b1, 7'h44, 7'h12}) begin
                    errors++;
                    $display("FAIL sub_issue got op=%b a=%h b=%h exp op=1 a=44 b=12", fu_op, fu_a, fu_b);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL sub_busy_high n=%0d got=%b exp=1", n, busy);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL sub_busy_done got busy=%b rsp_v=%b exp busy=0 rsp_v=01", busy, rsp_valid);
        end
        @(posedge clk);
        #1 drain();
    endtask

    task automatic test_reset_mid();
        int hits;
        rand_req(1);
        req_valid = 2'b10;
        @(posedge clk);
        #1 rand_req(0);
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        hits = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid !== '0) hits++;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_busy n=%0d got=%b exp=0", n, busy);
            end
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL rstmid_no_response got=%0d strobes exp=0", hits);
        end
        @(posedge clk);
        #1 rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_ptr got=%b exp=01", req_ready);
        end
        @(posedge clk);
        #1 drain();
    endtask

    task automatic test_idle();
        set_req(1, 7'h5A, 7'h0F, 1'b1);
        req_valid = 2'b10;
        @(posedge clk);
        #1 req_valid = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n > 0) begin
                checks++;
                if (fu_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_fu_valid n=%0d got=%b exp=0", n, fu_valid);
                end
            end
            checks++;
            if (fu_a !== 7'h5A || fu_b !== 7'h0F) begin
                errors++;
                $display("FAIL idle_hold n=%0d got a=%h b=%h exp a=5a b=0f", n, fu_a, fu_b);
            end
            if (n > LAT) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_busy n=%0d got=%b exp=0", n, busy);
                end
            end
            if (n != LAT + 1) begin
                checks++;
                if (rsp_valid !== '0) begin
                    errors++;
                    $display("FAIL idle_rsp n=%0d got=%b exp=00", n, rsp_valid);
                end
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_random();
        int grants, rsps;
        logic [NREQ-1:0] seen_ready;
        grants = 0;
        rsps   = 0;
        for (int n = 0; n < 300 + LAT + 4; n++) begin
            @(negedge clk);
            seen_ready = req_ready;
            if ((req_valid & req_ready) != '0) grants++;
            if (rsp_valid != '0) rsps++;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (n >= 300) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && seen_ready[i]) begin
                    req_valid[i] = 1'($urandom);
                    rand_req(i);
                end else if (req_valid[i]) begin
                    if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    req_valid[i] = 1'b1;
                    rand_req(i);
                end
            end
        end
        checks++;
        if (grants != rsps || grants == 0) begin
            errors++;
            $display("FAIL random_count got %0d responses for %0d grants", rsps, grants);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_only_req1();
        test_sub_busy();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
